// File: rtl/calc_alu_pkg.sv
// Shared constants for the calculator ALU: opcodes, flag bit positions, FSM states.
package calc_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  // Bit positions inside FLAGS; the downstream flags register uses the same map.
  localparam int unsigned FLG_V = 0;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_Z = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ITER   = 2'b01,
    FINISH = 2'b10
  } state_e;

endpackage

// File: rtl/calc_alu_if.sv
// Request/response bundle between the calculator sequencer and the ALU.
interface calc_alu_if #(
  parameter int unsigned WIDTH = 8
);

  logic             START;
  logic [2:0]       OP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;
  logic [WIDTH-1:0] RESULT_HI;
  logic             ERR;
  logic [3:0]       FLAGS;
  logic             FLAGS_EN;

  modport master (
    output START, OP, A, B,
    input  BUSY, DONE, RESULT, RESULT_HI, ERR, FLAGS, FLAGS_EN
  );

  modport slave (
    input  START, OP, A, B,
    output BUSY, DONE, RESULT, RESULT_HI, ERR, FLAGS, FLAGS_EN
  );

endinterface

// File: rtl/calc_muldiv_core.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine, one step per clock.
module calc_muldiv_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             last_o
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q;
  logic             is_div_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   sub_w;
  logic             qbit;

  // One step of the selected algorithm. MUL: {hi,lo} holds partial product and
  // remaining multiplier bits. DIV: hi holds the partial remainder, lo shifts the
  // dividend out at the top while quotient bits enter at the bottom.
  always_comb begin
    add_w = {1'b0, hi_q};
    shl_w = {hi_q, lo_q[WIDTH-1]};
    sub_w = shl_w - {1'b0, opnd_q};
    qbit  = 1'b0;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (is_div_q) begin
      qbit = (shl_w >= {1'b0, opnd_q});
      hi_d = qbit ? sub_w[WIDTH-1:0] : shl_w[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], qbit};
    end else begin
      if (lo_q[0]) begin
        add_w = {1'b0, hi_q} + {1'b0, opnd_q};
      end
      hi_d = add_w[WIDTH:1];
      lo_d = {add_w[0], lo_q[WIDTH-1:1]};
    end
  end

  // Operand load on acceptance, then one algorithm step per enabled clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else if (load_i) begin
      hi_q     <= '0;
      lo_q     <= a_i;
      opnd_q   <= b_i;
      is_div_q <= is_div_i;
      cnt_q    <= '0;
    end else if (step_i) begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign lo_o   = lo_q;
  assign hi_o   = hi_q;
  assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/calc_alu.sv
// Calculator ALU: request FSM, single-cycle arithmetic/logic, flag generation.
module calc_alu
  import calc_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  calc_alu_if.slave bus
);

  state_e state_q, state_d;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic             done_q;

  logic             accept;
  logic             core_load;
  logic             core_step;
  logic             core_last;
  logic [WIDTH-1:0] core_lo;
  logic [WIDTH-1:0] core_hi;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic             c_c;
  logic             v_c;

  assign accept    = (state_q == IDLE) && bus.START;
  // Divide-by-zero never enters the iterative engine.
  assign core_load = accept && ((bus.OP == OP_MUL) ||
                                ((bus.OP == OP_DIV) && (bus.B != '0)));
  assign core_step = (state_q == ITER);

  calc_muldiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i    (CLK),
    .rst_i    (RST),
    .load_i   (core_load),
    .is_div_i (bus.OP == OP_DIV),
    .a_i      (bus.A),
    .b_i      (bus.B),
    .step_i   (core_step),
    .lo_o     (core_lo),
    .hi_o     (core_hi),
    .last_o   (core_last)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = core_load ? ITER : FINISH;
        end
      end
      ITER: begin
        if (core_last) begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request so later operand changes cannot disturb it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q <= OP_ADD;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= bus.OP;
      a_q  <= bus.A;
      b_q  <= bus.B;
    end
  end

  // Result and flag computation, consumed in FINISH.
  always_comb begin
    sum_w    = {1'b0, a_q} + {1'b0, b_q};
    diff_w   = {1'b0, a_q} - {1'b0, b_q};
    result_d = '0;
    hi_d     = '0;
    err_d    = 1'b0;
    c_c      = 1'b0;
    v_c      = 1'b0;
    case (op_q)
      OP_ADD: begin
        result_d = sum_w[WIDTH-1:0];
        c_c      = sum_w[WIDTH];
        v_c      = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (sum_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        result_d = diff_w[WIDTH-1:0];
        c_c      = diff_w[WIDTH];
        v_c      = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                   (diff_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  result_d = a_q & b_q;
      OP_OR:   result_d = a_q | b_q;
      OP_XOR:  result_d = a_q ^ b_q;
      OP_MUL: begin
        result_d = core_lo;
        hi_d     = core_hi;
        c_c      = (core_hi != '0);
        v_c      = (core_hi != '0);
      end
      OP_DIV: begin
        if (b_q == '0) begin
          result_d = '1;
          hi_d     = a_q;
          err_d    = 1'b1;
        end else begin
          result_d = core_lo;
          hi_d     = core_hi;
        end
      end
      default: err_d = 1'b1;
    endcase

    flags_d        = '0;
    flags_d[FLG_V] = v_c;
    flags_d[FLG_C] = c_c;
    flags_d[FLG_N] = result_d[WIDTH-1];
    flags_d[FLG_Z] = (result_d == '0);
    // Divide-by-zero reports only V regardless of the all-ones result.
    if ((op_q == OP_DIV) && (b_q == '0)) begin
      flags_d        = '0;
      flags_d[FLG_V] = 1'b1;
    end
  end

  // Output registers: load once per operation and pulse DONE/FLAGS_EN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      result_q <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == FINISH);
      if (state_q == FINISH) begin
        result_q <= result_d;
        hi_q     <= hi_d;
        flags_q  <= flags_d;
        err_q    <= err_d;
      end
    end
  end

  assign bus.BUSY      = (state_q != IDLE);
  assign bus.DONE      = done_q;
  assign bus.FLAGS_EN  = done_q;
  assign bus.RESULT    = result_q;
  assign bus.RESULT_HI = hi_q;
  assign bus.FLAGS     = flags_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_calc_alu.sv
// Directed self-checking bench for calc_alu (WIDTH=8).
module tb_calc_alu;
  import calc_alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  calc_alu_if #(.WIDTH(8)) bus ();

  calc_alu #(
    .WIDTH(8)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Every DONE pulse seen anywhere in the run.
  always @(negedge clk) begin
    if (bus.DONE === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request so that it is accepted on the next rising edge (edge k);
  // returns #1 after edge k with START dropped and operands scrambled.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.START = 1'b1;
    bus.OP    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
  endtask

  // Wait (bounded) for DONE; latency is counted in edges after edge k.
  // With poke set, extra START requests are driven while the op is running.
  task automatic wait_done(input int lat, input bit poke, input string tag);
    int n      = 0;
    int busy_n = 0;
    while (bus.DONE !== 1'b1 && n < 40) begin
      if (bus.BUSY === 1'b1) busy_n++;
      if (poke && n < lat - 1) begin
        bus.START = 1'b1;
        bus.OP    = OP_ADD;
        bus.A     = 8'h01;
        bus.B     = 8'h01;
      end else begin
        bus.START = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.START = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat));
    check({tag, "_busy_at_done"}, 32'(bus.BUSY), 32'(0));
    check({tag, "_flags_en"}, 32'(bus.FLAGS_EN), 32'(1));
  endtask

  task automatic check_res(input string tag, input logic [7:0] res, input logic [7:0] hi,
                           input logic [3:0] flags, input logic err);
    check({tag, "_result"}, 32'(bus.RESULT), 32'(res));
    check({tag, "_result_hi"}, 32'(bus.RESULT_HI), 32'(hi));
    check({tag, "_flags"}, 32'(bus.FLAGS), 32'(flags));
    check({tag, "_err"}, 32'(bus.ERR), 32'(err));
  endtask

  // One cycle after DONE: strobes gone, outputs held, nothing running.
  task automatic check_hold(input string tag, input logic [7:0] res, input logic [3:0] flags);
    @(posedge clk);
    #1;
    check({tag, "_done_single"}, 32'(bus.DONE), 32'(0));
    check({tag, "_flags_en_single"}, 32'(bus.FLAGS_EN), 32'(0));
    check({tag, "_idle_after"}, 32'(bus.BUSY), 32'(0));
    check({tag, "_result_held"}, 32'(bus.RESULT), 32'(res));
    check({tag, "_flags_held"}, 32'(bus.FLAGS), 32'(flags));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.BUSY), 32'(0));
    check({tag, "_done"}, 32'(bus.DONE), 32'(0));
    check({tag, "_flags_en"}, 32'(bus.FLAGS_EN), 32'(0));
    check({tag, "_result"}, 32'(bus.RESULT), 32'(0));
    check({tag, "_result_hi"}, 32'(bus.RESULT_HI), 32'(0));
    check({tag, "_flags"}, 32'(bus.FLAGS), 32'(0));
    check({tag, "_err"}, 32'(bus.ERR), 32'(0));
  endtask

  initial begin
    rst       = 1'b1;
    bus.START = 1'b0;
    bus.OP    = OP_ADD;
    bus.A     = 8'h00;
    bus.B     = 8'h00;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD 0x7F+0x01 = 0x80: signed overflow, negative
    issue(OP_ADD, 8'h7F, 8'h01);
    wait_done(1, 1'b0, "add_ovf");
    check_res("add_ovf", 8'h80, 8'h00, 4'b0101, 1'b0);
    check_hold("add_ovf", 8'h80, 4'b0101);

    // SUB 0x00-0x01 = 0xFF: borrow, negative
    issue(OP_SUB, 8'h00, 8'h01);
    wait_done(1, 1'b0, "sub_borrow");
    check_res("sub_borrow", 8'hFF, 8'h00, 4'b0110, 1'b0);

    // XOR equal operands -> zero
    issue(OP_XOR, 8'h5A, 8'h5A);
    wait_done(1, 1'b0, "xor_zero");
    check_res("xor_zero", 8'h00, 8'h00, 4'b1000, 1'b0);

    // SUB 0x80-0x01 = 0x7F: signed overflow, no borrow
    issue(OP_SUB, 8'h80, 8'h01);
    wait_done(1, 1'b0, "sub_ovf");
    check_res("sub_ovf", 8'h7F, 8'h00, 4'b0001, 1'b0);

    // AND 0xF0&0x3C = 0x30
    issue(OP_AND, 8'hF0, 8'h3C);
    wait_done(1, 1'b0, "and");
    check_res("and", 8'h30, 8'h00, 4'b0000, 1'b0);

    // OR 0x80|0x01 = 0x81: negative
    issue(OP_OR, 8'h80, 8'h01);
    wait_done(1, 1'b0, "or");
    check_res("or", 8'h81, 8'h00, 4'b0100, 1'b0);

    // ADD 0xFF+0x01 = 0x00: carry, zero, no signed overflow
    issue(OP_ADD, 8'hFF, 8'h01);
    wait_done(1, 1'b0, "add_carry");
    check_res("add_carry", 8'h00, 8'h00, 4'b1010, 1'b0);

    // MUL 0x10*0x10 = 0x0100 with START pokes while busy
    issue(OP_MUL, 8'h10, 8'h10);
    wait_done(9, 1'b1, "mul_16");
    check_res("mul_16", 8'h00, 8'h01, 4'b1011, 1'b0);
    check_hold("mul_16", 8'h00, 4'b1011);

    // MUL 0xFF*0xFF = 0xFE01
    issue(OP_MUL, 8'hFF, 8'hFF);
    wait_done(9, 1'b0, "mul_ff");
    check_res("mul_ff", 8'h01, 8'hFE, 4'b0011, 1'b0);

    // DIV 100/7 = 14 r 2
    issue(OP_DIV, 8'd100, 8'd7);
    wait_done(9, 1'b0, "div");
    check_res("div", 8'h0E, 8'h02, 4'b0000, 1'b0);

    // DIV 0xFF/0x10 = 15 r 15
    issue(OP_DIV, 8'hFF, 8'h10);
    wait_done(9, 1'b0, "div_ff");
    check_res("div_ff", 8'h0F, 8'h0F, 4'b0000, 1'b0);

    // DIV by zero finishes without iterating
    issue(OP_DIV, 8'h05, 8'h00);
    wait_done(1, 1'b0, "div0");
    check_res("div0", 8'hFF, 8'h05, 4'b0001, 1'b1);

    // Reset during MUL step 4 aborts the operation
    issue(OP_MUL, 8'h10, 8'h10);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(OP_ADD, 8'h01, 8'h02);
    wait_done(1, 1'b0, "add_after_rst");
    check_res("add_after_rst", 8'h03, 8'h00, 4'b0000, 1'b0);

    // Back-to-back: reserved opcode requested in the ADD's DONE cycle
    issue(OP_ADD, 8'h22, 8'h11);
    wait_done(1, 1'b0, "add_b2b");
    check_res("add_b2b", 8'h33, 8'h00, 4'b0000, 1'b0);
    bus.START = 1'b1;
    bus.OP    = OP_RSVD;
    bus.A     = 8'h55;
    bus.B     = 8'hAA;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    wait_done(1, 1'b0, "rsvd");
    check_res("rsvd", 8'h00, 8'h00, 4'b1000, 1'b1);
    check_hold("rsvd", 8'h00, 4'b1000);

    // The aborted MUL must never have produced a DONE
    check("done_pulse_count", 32'(done_cnt), 32'(15));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_alu.md
Name: calc_alu

Overview:
Sequential ALU for the pocket calculator datapath. It sits directly upstream of the flags register. It accepts an opcode and two operands on a START strobe, runs add/sub/logic ops in one cycle and mul/div iteratively. It then returns RESULT together with a packed 4-bit flag vector and a one-cycle enable strobe that drive the flags register's IN and EN inputs.

Parameters:
WIDTH, 8, operand/result width in bits (minimum 4).

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  reset, asynchronous, active-high
START  input  1  request strobe; sampled only in IDLE
OP  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 DIV, 111 reserved
A  input  WIDTH  operand A (unsigned for MUL/DIV; two's complement for V on ADD/SUB)
B  input  WIDTH  operand B
BUSY  output  1  operation in progress
DONE  output  1  one-cycle pulse: results valid
RESULT  output  WIDTH  sum/difference/logic result, low product half, or quotient
RESULT_HI  output  WIDTH  high product half (MUL) or remainder (DIV); 0 otherwise
ERR  output  1  divide-by-zero or reserved opcode
FLAGS  output  4  bit0 V (overflow), bit1 C (carry), bit2 N (negative), bit3 Z (zero)
FLAGS_EN  output  1  asserted in the same cycle as DONE; drives the flags register EN

Behaviour:
- Reset state: IDLE. BUSY, DONE, FLAGS_EN, ERR, FLAGS, RESULT and RESULT_HI are all 0. Internal registers are cleared.
- FSM states:
  - IDLE: START=1 at edge k latches OP, A, B. ADD/SUB/logic/reserved/div-by-zero go to FINISH. MUL/DIV go to ITER.
  - ITER: one shift-add (MUL) or restoring-subtract (DIV) step per edge. Runs exactly WIDTH steps, then goes to FINISH.
  - FINISH: registers the outputs and pulses DONE/FLAGS_EN, then returns to IDLE.
- Latency:
  - Single-cycle ops: DONE high after edge k+1.
  - MUL/DIV: DONE high after edge k+WIDTH+1.
- BUSY: high from edge k until the edge that raises DONE; low while DONE is high.
- START while BUSY: ignored, with no effect on the running op. START while DONE is high is accepted, giving back-to-back ops.
- Output hold: RESULT, RESULT_HI, FLAGS and ERR hold their values until the next DONE. DONE and FLAGS_EN are single-cycle.
- Flag rules: N = RESULT[WIDTH-1] and Z = (RESULT==0) for all ops, unless an override below applies.
  - ADD: C = carry out; V = signed overflow (operands same sign, result sign differs).
  - SUB (A-B): C = borrow, i.e. 1 iff A<B unsigned; V = signed overflow (operand signs differ, result sign differs from A).
  - AND/OR/XOR: C=0, V=0.
  - MUL: unsigned WIDTH x WIDTH to 2*WIDTH product. C = V = (RESULT_HI != 0).
  - DIV: unsigned. RESULT = quotient, RESULT_HI = remainder, C=0, V=0.
  - DIV with B==0: detected at IDLE and finished without iterating. RESULT = all ones, RESULT_HI = A, ERR=1. FLAGS: V=1, C=0, N=0, Z=0 (overrides the rule above).
  - Reserved OP 111: RESULT=0, RESULT_HI=0, ERR=1, FLAGS: Z=1, others 0.
- Reset mid-operation: aborts immediately. All outputs return to reset values, no DONE is produced, and START is accepted on the first edge after RST deasserts.
- Operands A/B may change after the accepting edge without affecting the result.

Decomposition:
- Package calc_alu_pkg holds:
  - opcode constants (OP_ADD..OP_RSVD)
  - flag bit indices (FLG_V=0, FLG_C=1, FLG_N=2, FLG_Z=3), shared with the flags register
  - state encoding (IDLE, ITER, FINISH)
- Sub-module calc_muldiv_core (WIDTH-parameterised iterative shift-add/restoring-divide engine with its step counter) is natural. The top level keeps the FSM, single-cycle ops and flag generation.

Test Plan:
- ADD A=0x7F B=0x01 -> DONE after edge k+1; RESULT=0x80, FLAGS=4'b0101 (N,V), FLAGS_EN=1 for one cycle.
- SUB A=0x00 B=0x01 -> RESULT=0xFF, FLAGS=4'b0110 (N,C); XOR A=0x5A B=0x5A -> RESULT=0x00, FLAGS=4'b1000.
- MUL A=0x10 B=0x10 -> DONE after edge k+9; RESULT=0x00, RESULT_HI=0x01, FLAGS=4'b1011; BUSY high 9 cycles; START pulses during BUSY ignored.
- DIV A=100 B=7 -> after edge k+9, RESULT=0x0E, RESULT_HI=0x02, FLAGS=4'b0000, ERR=0; then DIV A=0x05 B=0 -> DONE after 1 cycle, RESULT=0xFF, RESULT_HI=0x05, ERR=1, FLAGS=4'b0001.
- RST pulsed during MUL step 4 -> all outputs 0, no DONE; a new ADD 0x01+0x02 issued after reset -> RESULT=0x03, FLAGS=4'b0000.
- Back-to-back: START asserted in the DONE cycle of an ADD with OP=111 -> accepted; next DONE gives ERR=1, RESULT=0, FLAGS=4'b1000.
